// File: rtl/imm_gen_pkg.sv
// Shared immediate type codes, RISC-V opcodes, skid-buffer states and opcode decoder.
// Optional macro IMM_GEN_ZICSR_EN: SYSTEM opcode decodes to the Z (zimm) type instead of I.
package imm_gen_pkg;

    localparam logic [2:0] IMM_R  = 3'b000;
    localparam logic [2:0] IMM_I  = 3'b001;
    localparam logic [2:0] IMM_S  = 3'b010;
    localparam logic [2:0] IMM_B  = 3'b011;
    localparam logic [2:0] IMM_U  = 3'b100;
    localparam logic [2:0] IMM_J  = 3'b101;
    localparam logic [2:0] IMM_Z  = 3'b110;
    localparam logic [2:0] IMM_I2 = 3'b111;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

    // Returns {illegal, type}; unknown opcodes resolve to R and flag illegal.
    function automatic logic [3:0] decode_opcode(input logic [6:0] opcode);
        logic [2:0] ty;
        logic       ill;
        ty  = IMM_R;
        ill = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_OP_IMM_32: ty = IMM_I;
            OPC_STORE:                                     ty = IMM_S;
            OPC_BRANCH:                                    ty = IMM_B;
            OPC_LUI, OPC_AUIPC:                            ty = IMM_U;
            OPC_JAL:                                       ty = IMM_J;
`ifdef IMM_GEN_ZICSR_EN
            OPC_SYSTEM:                                    ty = IMM_Z;
`else
            OPC_SYSTEM:                                    ty = IMM_I;
`endif
            OPC_OP, OPC_OP_32:                             ty = IMM_R;
            default:                                       ill = 1'b1;
        endcase
        return {ill, ty};
    endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate builder: instruction bits + type code -> sign-extended XLEN immediate.
// Optional macro IMM_GEN_ZICSR_EN: type Z yields zero-extended zimm, otherwise it is illegal.
module imm_gen_core
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instr_i,
    input  logic [2:0]      imm_type_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    always_comb begin
        imm_o     = '0;
        illegal_o = 1'b0;
        case (imm_type_i)
            IMM_I, IMM_I2: imm_o = XLEN'($signed(instr_i[31:20]));
            IMM_S:         imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            IMM_B:         imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                                  instr_i[11:8], 1'b0}));
            // Sign-extending the 32-bit value keeps RV64 LUI semantics.
            IMM_U:         imm_o = XLEN'($signed({instr_i[31:12], 12'h000}));
            IMM_J:         imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                                  instr_i[30:21], 1'b0}));
`ifdef IMM_GEN_ZICSR_EN
            IMM_Z:         imm_o = XLEN'(instr_i[19:15]);
`else
            IMM_Z:         illegal_o = 1'b1;
`endif
            default:       imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready input and a 2-entry skid buffer on the output.
// Optional macro IMM_GEN_ZICSR_EN (see imm_gen_core / imm_gen_pkg) enables zimm generation.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TAG_W       = 32,
    parameter bit          AUTO_DECODE = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [31:0]      instr_in,
    input  logic [2:0]       imm_type_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       imm_type_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             illegal_out
);

    logic [2:0]      dec_type, res_type;
    logic            dec_illegal, core_illegal, res_illegal;
    logic [XLEN-1:0] core_imm;

    assign {dec_illegal, dec_type} = decode_opcode(instr_in[6:0]);
    assign res_type                = AUTO_DECODE ? dec_type : imm_type_in;
    assign res_illegal             = core_illegal | (AUTO_DECODE & dec_illegal);

    imm_gen_core #(
        .XLEN (XLEN)
    ) u_core (
        .instr_i    (instr_in[31:7]),
        .imm_type_i (res_type),
        .imm_o      (core_imm),
        .illegal_o  (core_illegal)
    );

    skid_state_e     state_q, state_d;
    logic            in_ready_q;
    logic [XLEN-1:0] main_imm_q, skid_imm_q;
    logic [2:0]      main_type_q, skid_type_q;
    logic [TAG_W-1:0] main_tag_q, skid_tag_q;
    logic            main_ill_q, skid_ill_q;
    logic            accept, pop, load_main, load_skid, skid_to_main;

    assign accept = in_valid_in & in_ready_q;
    assign pop    = out_valid_out & out_ready_in;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d   = StOne;
                    load_main = 1'b1;
                end
            end
            StOne: begin
                if (accept && !pop) begin
                    state_d   = StFull;
                    load_skid = 1'b1;
                end else if (accept && pop) begin
                    load_main = 1'b1;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    state_d      = StOne;
                    skid_to_main = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            main_imm_q  <= '0;
            main_type_q <= '0;
            main_tag_q  <= '0;
            main_ill_q  <= 1'b0;
            skid_imm_q  <= '0;
            skid_type_q <= '0;
            skid_tag_q  <= '0;
            skid_ill_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StFull);
            if (load_main) begin
                main_imm_q  <= core_imm;
                main_type_q <= res_type;
                main_tag_q  <= tag_in;
                main_ill_q  <= res_illegal;
            end else if (skid_to_main) begin
                main_imm_q  <= skid_imm_q;
                main_type_q <= skid_type_q;
                main_tag_q  <= skid_tag_q;
                main_ill_q  <= skid_ill_q;
            end
            if (load_skid) begin
                skid_imm_q  <= core_imm;
                skid_type_q <= res_type;
                skid_tag_q  <= tag_in;
                skid_ill_q  <= res_illegal;
            end
        end
    end

    assign in_ready_out  = in_ready_q;
    assign out_valid_out = (state_q != StEmpty);
    assign imm_out       = main_imm_q;
    assign imm_type_out  = main_type_q;
    assign tag_out       = main_tag_q;
    assign illegal_out   = main_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: an RV32 manual-type instance and an RV64 auto-decode instance share stimulus.
`timescale 1ns/1ps
module tb_imm_gen_pipe;

`ifdef IMM_GEN_ZICSR_EN
    localparam bit ZICSR = 1'b1;
`else
    localparam bit ZICSR = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, out_ready;
    logic [31:0] instr, tag;
    logic [2:0]  itype;

    logic        a_in_ready, a_out_valid, a_ill;
    logic [31:0] a_imm, a_tag;
    logic [2:0]  a_type;
    logic        b_in_ready, b_out_valid, b_ill;
    logic [63:0] b_imm;
    logic [31:0] b_tag;
    logic [2:0]  b_type;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(1'b0)) u_dut32 (
        .clk_in(clk), .rst_n_in(rst_n), .in_valid_in(in_valid), .in_ready_out(a_in_ready),
        .instr_in(instr), .imm_type_in(itype), .tag_in(tag), .out_valid_out(a_out_valid),
        .out_ready_in(out_ready), .imm_out(a_imm), .imm_type_out(a_type), .tag_out(a_tag),
        .illegal_out(a_ill)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .AUTO_DECODE(1'b1)) u_dut64 (
        .clk_in(clk), .rst_n_in(rst_n), .in_valid_in(in_valid), .in_ready_out(b_in_ready),
        .instr_in(instr), .imm_type_in(itype), .tag_in(tag), .out_valid_out(b_out_valid),
        .out_ready_in(out_ready), .imm_out(b_imm), .imm_type_out(b_type), .tag_out(b_tag),
        .illegal_out(b_ill)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  ty;
        logic [31:0] tag;
        logic        ill;
    } exp_t;

    exp_t q32[$], q64[$];
    exp_t e32, e64;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [2:0] ty_in, input bit auto,
                                   input bit xlen64, input logic [31:0] tg);
        exp_t              e;
        logic [2:0]        ty;
        logic              ill;
        logic signed [31:0] si;
        logic signed [63:0] v;
        si  = ins;
        ty  = ty_in;
        ill = 1'b0;
        if (auto) begin
            case (ins[6:0])
                7'h03, 7'h13, 7'h67, 7'h1B: ty = 3'd1;
                7'h23:                      ty = 3'd2;
                7'h63:                      ty = 3'd3;
                7'h37, 7'h17:               ty = 3'd4;
                7'h6F:                      ty = 3'd5;
                7'h73:                      ty = ZICSR ? 3'd6 : 3'd1;
                7'h33, 7'h3B:               ty = 3'd0;
                default: begin ty = 3'd0; ill = 1'b1; end
            endcase
        end
        case (ty)
            3'd1, 3'd7: v = si >>> 20;
            3'd2: begin v = si >>> 25; v = (v << 5) | {59'b0, ins[11:7]}; end
            3'd3: begin
                v = si >>> 31;
                v = (v << 12) | {51'b0, ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            3'd4: begin v = si; v[11:0] = 12'h0; end
            3'd5: begin
                v = si >>> 31;
                v = (v << 20) | {44'b0, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            3'd6: begin
                v = ZICSR ? {59'b0, ins[19:15]} : 64'd0;
                if (!ZICSR) ill = 1'b1;
            end
            default: v = 64'd0;
        endcase
        e.imm = xlen64 ? v : {32'b0, v[31:0]};
        e.ty  = ty;
        e.tag = tg;
        e.ill = ill;
        return e;
    endfunction

    // Outputs are compared on the falling edge; accepts are predicted for the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            q64.delete();
        end else begin
            if (a_out_valid && out_ready) begin
                if (q32.size() == 0) check_eq("dut32 spurious output", 64'(q32.size()), 64'd1);
                else begin
                    e32 = q32.pop_front();
                    check_eq("dut32 imm", {32'b0, a_imm}, e32.imm);
                    check_eq("dut32 type", 64'(a_type), 64'(e32.ty));
                    check_eq("dut32 tag", 64'(a_tag), 64'(e32.tag));
                    check_eq("dut32 illegal", 64'(a_ill), 64'(e32.ill));
                end
            end
            if (b_out_valid && out_ready) begin
                if (q64.size() == 0) check_eq("dut64 spurious output", 64'(q64.size()), 64'd1);
                else begin
                    e64 = q64.pop_front();
                    check_eq("dut64 imm", b_imm, e64.imm);
                    check_eq("dut64 type", 64'(b_type), 64'(e64.ty));
                    check_eq("dut64 tag", 64'(b_tag), 64'(e64.tag));
                    check_eq("dut64 illegal", 64'(b_ill), 64'(e64.ill));
                end
            end
            if (in_valid && a_in_ready) q32.push_back(model(instr, itype, 1'b0, 1'b0, tag));
            if (in_valid && b_in_ready) q64.push_back(model(instr, itype, 1'b1, 1'b1, tag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] ty, input logic [31:0] tg);
        int   n;
        logic ok;
        n        = 0;
        in_valid = 1'b1;
        instr    = ins;
        itype    = ty;
        tag      = tg;
        do begin
            @(negedge clk);
            ok = a_in_ready;
            n++;
            tick();
        end while (!ok && n < 50);
        if (!ok) check_eq("send timeout", 64'(ok), 64'd1);
        in_valid = 1'b0;
    endtask

    logic [6:0] opcs [13];

    initial begin
        opcs = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33,
                 7'h3B, 7'h7F};
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = 32'hFFF00093;
        itype     = 3'd1;
        tag       = 32'hDEAD0000;

        // Reset held with valid asserted.
        repeat (2) begin
            @(negedge clk);
            check_eq("reset out_valid", 64'(a_out_valid), 64'd0);
            check_eq("reset in_ready", 64'(a_in_ready), 64'd1);
            check_eq("reset imm", 64'(a_imm), 64'd0);
            check_eq("reset out_valid64", 64'(b_out_valid), 64'd0);
        end
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();

        send(32'hFFF00093, 3'd1, 32'hA5A50001);
        @(negedge clk);
        check_eq("I latency valid", 64'(a_out_valid), 64'd1);
        check_eq("I imm", 64'(a_imm), 64'hFFFFFFFF);
        check_eq("I tag", 64'(a_tag), 64'hA5A50001);
        tick();

        send(32'hFE000EE3, 3'd3, 32'hA5A50002);
        @(negedge clk);
        check_eq("auto B imm", b_imm, 64'hFFFFFFFFFFFFFFFC);
        check_eq("auto B type", 64'(b_type), 64'd3);
        tick();

        send(32'h800002B7, 3'd4, 32'hA5A50003);
        @(negedge clk);
        check_eq("auto U imm64", b_imm, 64'hFFFFFFFF80000000);
        tick();

        send(32'h340FD073, 3'd6, 32'hA5A50004);
        @(negedge clk);
        check_eq("zicsr imm", 64'(a_imm), ZICSR ? 64'h1F : 64'h0);
        check_eq("zicsr illegal", 64'(a_ill), ZICSR ? 64'd0 : 64'd1);
        tick();
        tick();

        // Backpressure: fill both entries, third request must stall.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00100093;
        itype     = 3'd1;
        tag       = 32'd1;
        tick();
        tag = 32'd2;
        tick();
        tag = 32'd3;
        repeat (2) begin
            @(negedge clk);
            check_eq("full in_ready", 64'(a_in_ready), 64'd0);
            check_eq("held tag", 64'(a_tag), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("drain1 valid", 64'(a_out_valid), 64'd1);
        check_eq("drain1 tag", 64'(a_tag), 64'd1);
        tick();
        @(negedge clk);
        check_eq("drain2 tag", 64'(a_tag), 64'd2);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("drain3 valid", 64'(a_out_valid), 64'd1);
        check_eq("drain3 tag", 64'(a_tag), 64'd3);
        tick();

        // Reset while full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tag       = 32'd4;
        tick();
        tag = 32'd5;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("pre-reset full", 64'(a_in_ready), 64'd0);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check_eq("mid reset out_valid", 64'(a_out_valid), 64'd0);
        check_eq("mid reset in_ready", 64'(a_in_ready), 64'd1);
        check_eq("mid reset tag", 64'(a_tag), 64'd0);
        check_eq("mid reset out_valid64", 64'(b_out_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic with random backpressure.
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            instr     = {$urandom_range(0, 32'h01FFFFFF), opcs[$urandom_range(0, 12)]};
            itype     = 3'($urandom_range(0, 7));
            tag       = 32'h1000 + 32'(i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) tick();
        check_eq("drain q32 empty", 64'(q32.size()), 64'd0);
        check_eq("drain q64 empty", 64'(q64.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered successor to the combinational immediate generator.
- Accepts a full instruction word plus an optional tag (e.g. PC) over a valid/ready handshake.
- Builds the sign-extended immediate at XLEN width, either from an explicit type code or by decoding the opcode itself.
- Emits the result through a 2-entry skid buffer, so the decode stage gets full throughput with registered ready and valid.

Parameters:
- XLEN, 32, immediate output width; legal values are 32 and 64.
- TAG_W, 32, width of the sideband tag carried alongside each instruction.
- AUTO_DECODE, 0, 1 derives the immediate type from instr_in[6:0]; 0 uses imm_type_in.

Ports:
- clk_in  input  1  rising-edge clock
- rst_n_in  input  1  synchronous active-low reset
- in_valid_in  input  1  instruction valid
- in_ready_out  output  1  block can accept an instruction
- instr_in  input  32  instruction word
- imm_type_in  input  3  immediate type code; ignored when AUTO_DECODE=1
- tag_in  input  TAG_W  sideband tag
- out_valid_out  output  1  immediate valid
- out_ready_in  input  1  downstream accepts
- imm_out  output  XLEN  generated immediate
- imm_type_out  output  3  resolved type code
- tag_out  output  TAG_W  tag matching imm_out
- illegal_out  output  1  resolved type is unsupported

Behaviour:
- One clock, clk_in. Reset is synchronous and active-low on rst_n_in, sampled on the rising edge.
- Reset values: state EMPTY, out_valid_out=0, in_ready_out=1, imm_out=0, imm_type_out=0, tag_out=0, illegal_out=0.
- Type codes: 000 R (imm=0), 001 I, 010 S, 011 B, 100 U, 101 J, 110 Z (see optional feature), 111 I.
- Immediates are sign-extended from instr_in[31] to XLEN. U-type is {instr[31:12],12'h0} sign-extended, so RV64 LUI semantics hold.
- AUTO_DECODE opcode map:
  - 0000011/0010011/1100111/0011011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111/0010111 -> U
  - 1101111 -> J
  - 1110011 -> Z if ZICSR_EN, else I
  - 0110011/0111011 -> R
  - any other opcode -> R with illegal_out=1
- Immediate computation is combinational on the input side; the result is captured in the main register on accept (in_valid_in & in_ready_out).
- Latency: result visible one cycle after accept.
- Skid buffer state machine:
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> FULL, new entry goes to skid register. Accept & pop -> ONE, main register reloaded. Pop & !accept -> EMPTY.
  - FULL: pop -> ONE, skid register moves to main. No accept possible.
  - pop = out_valid_out & out_ready_in.
- in_ready_out is registered and equals (next_state != FULL).
- out_valid_out = (state != EMPTY).
- Outputs are held stable while out_valid_out & !out_ready_in.
- Order is strictly FIFO; no entry is ever dropped or duplicated.
- Reset asserted mid-operation: all entries are discarded at that edge and state returns to EMPTY.
- illegal_out travels with its entry, like the tag.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined: type 110 (and opcode 1110011 under AUTO_DECODE) yields the zero-extended 5-bit zimm instr[19:15]; illegal_out=0.
- Undefined: type 110 yields imm=0 with illegal_out=1; opcode 1110011 decodes as I.

Decomposition:
- Shared package imm_gen_pkg:
  - 3-bit imm type localparams (IMM_R..IMM_Z)
  - opcode constants
  - skid state encoding
- Natural sub-module: imm_gen_core, purely combinational, parametrised by XLEN: instr + type -> imm + illegal.
- imm_gen_pipe instantiates imm_gen_core and owns the handshake and storage.

Test Plan:
- Reset: hold rst_n_in=0 for 2 cycles with in_valid_in=1 -> out_valid_out=0, in_ready_out=1, imm_out=0 throughout.
- I-type, XLEN=32: instr 0xFFF00093, type 001, out_ready_in=1 -> one cycle later imm_out=0xFFFFFFFF, tag_out equals tag_in.
- B-type under AUTO_DECODE: instr 0xFE000EE3 -> imm_out=0xFFFFFFFC, imm_type_out=011.
- U-type, XLEN=64: instr 0x800002B7 -> imm_out=0xFFFFFFFF80000000.
- Backpressure:
  - Drive out_ready_in=0 and push tags 1, 2, 3 on consecutive cycles -> tags 1 and 2 accepted, in_ready_out=0 at tag 3, which is held.
  - Release out_ready_in -> outputs emerge in order 1, 2, 3 with no gaps.
  - Assert reset while FULL -> EMPTY next edge.
- ZICSR, with IMM_GEN_ZICSR_EN defined: instr 0x340FD073, type 110 -> imm_out=0x1F, illegal_out=0.
- ZICSR, macro undefined: same stimulus -> imm_out=0, illegal_out=1.
